// File: rtl/serial_slave.sv
// serial_slave: peripheral end of the 3-wire serial link, clocked by the master's serial clock.
// The FSM and transmit path run on falling edges; receive sampling runs on rising edges.
module serial_slave #(
    parameter int   BITS                 = 8,
    parameter logic LOWBIT_FIRST         = 1'b1,
    parameter logic SERIAL_DATA_INACTIVE = 1'b1
) (
    input  logic            serial_clk,
    input  logic            in_rst,
    input  logic            in_select,
    input  logic            in_serial,
    output logic            out_serial,
    input  logic [BITS-1:0] in_parallel,
    output logic [BITS-1:0] out_parallel,
    output logic            out_word_valid,
    output logic            out_next_word,
    output logic            out_busy
);

    localparam int CW = $clog2(BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   tx_ctr_q, tx_ctr_d;
    logic [BITS-1:0] tx_word_q, tx_word_d;
    logic [CW-1:0]   rx_ctr_q;
    logic [BITS-1:0] rx_shift_q, rx_next;
    logic [BITS-1:0] out_parallel_q;
    logic            out_word_valid_q;
    logic [BITS-1:0] tx_mask, rx_mask;

    // One-hot mask selecting the wire bit carried in slot c of a word
    function automatic logic [BITS-1:0] bit_mask(input logic [CW-1:0] c);
        return BITS'(1) << (LOWBIT_FIRST ? c : LAST - c);
    endfunction

    always_comb begin
        state_d   = state_q;
        tx_ctr_d  = tx_ctr_q;
        tx_word_d = tx_word_q;
        case (state_q)
            IDLE: begin
                if (in_select) begin
                    state_d   = SHIFT;
                    tx_word_d = in_parallel;
                    tx_ctr_d  = '0;
                end
            end
            SHIFT: begin
                if (!in_select) begin
                    state_d  = IDLE;
                    tx_ctr_d = '0;
                end else if (tx_ctr_q == LAST) begin
                    tx_word_d = in_parallel;
                    tx_ctr_d  = '0;
                end else begin
                    tx_ctr_d = tx_ctr_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= IDLE;
            tx_ctr_q  <= '0;
            tx_word_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_ctr_q  <= tx_ctr_d;
            tx_word_q <= tx_word_d;
        end
    end

    always_comb begin
        rx_mask = bit_mask(rx_ctr_q);
        rx_next = in_serial ? (rx_shift_q | rx_mask) : (rx_shift_q & ~rx_mask);
    end

    // Rising edges in Idle also rewind rx_ctr so an aborted word leaves no residue
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            rx_ctr_q         <= '0;
            rx_shift_q       <= '0;
            out_parallel_q   <= '0;
            out_word_valid_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            rx_shift_q <= rx_next;
            if (rx_ctr_q == LAST) begin
                out_parallel_q   <= rx_next;
                out_word_valid_q <= 1'b1;
                rx_ctr_q         <= '0;
            end else begin
                out_word_valid_q <= 1'b0;
                rx_ctr_q         <= rx_ctr_q + CW'(1);
            end
        end else begin
            out_word_valid_q <= 1'b0;
            rx_ctr_q         <= '0;
        end
    end

    assign tx_mask        = bit_mask(tx_ctr_q);
    assign out_serial     = (state_q == SHIFT) ? |(tx_word_q & tx_mask)
                                               : SERIAL_DATA_INACTIVE;
    assign out_next_word  = (state_q == SHIFT) && (tx_ctr_q == LAST);
    assign out_busy       = (state_q == SHIFT);
    assign out_parallel   = out_parallel_q;
    assign out_word_valid = out_word_valid_q;

endmodule

// File: tb/tb_serial_slave.sv
// Bench for serial_slave: three instances (8-bit LSB-first, 8-bit MSB-first, 12-bit LSB-first)
// share one serial clock; a scoreboard monitor checks every received and transmitted word.
module tb_serial_slave;

    logic clk = 1'b1;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic din = 1'b0;
    int   cur = 0;

    logic [7:0]  pin_a = 8'h00;
    logic [7:0]  pin_b = 8'h96;
    logic [11:0] pin_c = 12'h000;

    logic sel_a, sel_b, sel_c;
    assign sel_a = sel && (cur == 0);
    assign sel_b = sel && (cur == 1);
    assign sel_c = sel && (cur == 2);

    logic        so_a, so_b, so_c;
    logic [7:0]  po_a, po_b;
    logic [11:0] po_c;
    logic        val_a, val_b, val_c;
    logic        nw_a, nw_b, nw_c;
    logic        bs_a, bs_b, bs_c;

    initial forever #5 clk = ~clk;

    serial_slave #(.BITS(8), .LOWBIT_FIRST(1'b1), .SERIAL_DATA_INACTIVE(1'b1)) u_a (
        .serial_clk(clk), .in_rst(rst), .in_select(sel_a), .in_serial(din),
        .out_serial(so_a), .in_parallel(pin_a), .out_parallel(po_a),
        .out_word_valid(val_a), .out_next_word(nw_a), .out_busy(bs_a)
    );

    serial_slave #(.BITS(8), .LOWBIT_FIRST(1'b0), .SERIAL_DATA_INACTIVE(1'b1)) u_b (
        .serial_clk(clk), .in_rst(rst), .in_select(sel_b), .in_serial(din),
        .out_serial(so_b), .in_parallel(pin_b), .out_parallel(po_b),
        .out_word_valid(val_b), .out_next_word(nw_b), .out_busy(bs_b)
    );

    serial_slave #(.BITS(12), .LOWBIT_FIRST(1'b1), .SERIAL_DATA_INACTIVE(1'b1)) u_c (
        .serial_clk(clk), .in_rst(rst), .in_select(sel_c), .in_serial(din),
        .out_serial(so_c), .in_parallel(pin_c), .out_parallel(po_c),
        .out_word_valid(val_c), .out_next_word(nw_c), .out_busy(bs_c)
    );

    logic        so [3];
    logic        val[3];
    logic        nw [3];
    logic        bs [3];
    logic [15:0] po [3];

    assign so[0] = so_a;  assign so[1] = so_b;  assign so[2] = so_c;
    assign val[0] = val_a; assign val[1] = val_b; assign val[2] = val_c;
    assign nw[0] = nw_a;  assign nw[1] = nw_b;  assign nw[2] = nw_c;
    assign bs[0] = bs_a;  assign bs[1] = bs_b;  assign bs[2] = bs_c;
    assign po[0] = {8'h00, po_a};
    assign po[1] = {8'h00, po_b};
    assign po[2] = {4'h0, po_c};

    typedef struct {
        int          d;
        logic [15:0] w;
    } exp_t;

    exp_t rxq[$];
    exp_t txq[$];

    int checks = 0;
    int passed = 0;

    function automatic int nbits(input int d);
        return (d == 2) ? 12 : 8;
    endfunction

    function automatic bit lsbf(input int d);
        return d != 1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic push(input int d, input logic [15:0] rxw, input logic [15:0] txw);
        exp_t e;
        e.d = d;
        e.w = rxw;
        rxq.push_back(e);
        e.w = txw;
        txq.push_back(e);
    endtask

    task automatic push_tx(input int d, input logic [15:0] txw);
        exp_t e;
        e.d = d;
        e.w = txw;
        txq.push_back(e);
    endtask

    task automatic push_rx(input int d, input logic [15:0] rxw);
        exp_t e;
        e.d = d;
        e.w = rxw;
        rxq.push_back(e);
    endtask

    // Master side: present one bit per cycle, changed just after each rising edge
    task automatic xfer(input logic [15:0] w, input int n, input bit lsb);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            sel = 1'b1;
            din = w[lsb ? k : n - 1 - k];
        end
    endtask

    task automatic stop();
        @(posedge clk);
        #1;
        sel = 1'b0;
        din = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples all instances just after each rising edge
    initial begin : mon
        int          cnt[3];
        logic [15:0] acc[3];
        exp_t        e;
        int          bi;
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            acc[d] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (val[d]) begin
                    if (rxq.size() == 0) begin
                        checks++;
                        $display("FAIL rx%0d_unexpected: got valid word %h, required none", d, po[d]);
                    end else begin
                        e = rxq.pop_front();
                        chk($sformatf("rx%0d_src", d), 16'(d), 16'(e.d));
                        chk($sformatf("rx%0d_word", d), po[d], e.w);
                    end
                end
                if (bs[d]) begin
                    bi = lsbf(d) ? cnt[d] : nbits(d) - 1 - cnt[d];
                    if (bi >= 0 && bi < 16) acc[d][bi] = so[d];
                    if (nw[d]) begin
                        chk($sformatf("tx%0d_lastbit_pos", d), 16'(cnt[d]), 16'(nbits(d) - 1));
                        if (txq.size() == 0) begin
                            checks++;
                            $display("FAIL tx%0d_unexpected: got word %h, required none", d, acc[d]);
                        end else begin
                            e = txq.pop_front();
                            chk($sformatf("tx%0d_src", d), 16'(d), 16'(e.d));
                            chk($sformatf("tx%0d_word", d), acc[d], e.w);
                        end
                        cnt[d] = 0;
                        acc[d] = '0;
                    end else begin
                        cnt[d]++;
                    end
                end else begin
                    cnt[d] = 0;
                    acc[d] = '0;
                    chk($sformatf("idle%0d_serial", d), 16'(so[d]), 16'h0001);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_parallel", d), po[d], 16'h0000);
            chk($sformatf("rst%0d_valid", d), 16'(val[d]), 16'h0000);
            chk($sformatf("rst%0d_next", d), 16'(nw[d]), 16'h0000);
            chk($sformatf("rst%0d_busy", d), 16'(bs[d]), 16'h0000);
            chk($sformatf("rst%0d_serial", d), 16'(so[d]), 16'h0001);
        end
        rst = 1'b0;

        // 0xA5 in, 0x3C out, LSB first
        cur   = 0;
        pin_a = 8'h3C;
        push(0, 16'h00A5, 16'h003C);
        xfer(16'h00A5, 8, 1'b1);
        stop();
        idle(3);

        // MSB first, back-to-back, in_parallel changed during word 1
        cur   = 1;
        pin_b = 8'h96;
        push(1, 16'h0081, 16'h0096);
        push(1, 16'h007E, 16'h0055);
        fork
            begin
                repeat (4) @(posedge clk);
                pin_b = 8'h55;
            end
        join_none
        xfer(16'h0081, 8, 1'b0);
        xfer(16'h007E, 8, 1'b0);
        stop();
        idle(3);

        // select dropped after 5 bits: partial word discarded
        cur   = 0;
        pin_a = 8'h0F;
        xfer(16'h00FF, 5, 1'b1);
        stop();
        idle(2);
        chk("abort_parallel", {8'h00, po_a}, 16'h00A5);
        chk("abort_serial", 16'(so_a), 16'h0001);
        chk("abort_busy", 16'(bs_a), 16'h0000);
        pin_a = 8'hE7;
        push(0, 16'h0012, 16'h00E7);
        xfer(16'h0012, 8, 1'b1);
        stop();
        idle(3);

        // reset mid-word
        pin_a = 8'h99;
        xfer(16'h00C3, 3, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_parallel", {8'h00, po_a}, 16'h0000);
        chk("midrst_valid", 16'(val_a), 16'h0000);
        chk("midrst_next", 16'(nw_a), 16'h0000);
        chk("midrst_busy", 16'(bs_a), 16'h0000);
        chk("midrst_serial", 16'(so_a), 16'h0001);
        sel = 1'b0;
        #1;
        rst = 1'b0;
        idle(2);
        pin_a = 8'h5A;
        push(0, 16'h00C3, 16'h005A);
        xfer(16'h00C3, 8, 1'b1);
        stop();
        idle(3);

        // 12-bit words, back-to-back to exercise counter wrap
        cur   = 2;
        pin_c = 12'h5A5;
        push(2, 16'h0ABC, 16'h05A5);
        push_rx(2, 16'h0123);
        push_tx(2, 16'h03C9);
        fork
            begin
                repeat (4) @(posedge clk);
                pin_c = 12'h3C9;
            end
        join_none
        xfer(16'h0ABC, 12, 1'b1);
        xfer(16'h0123, 12, 1'b1);
        stop();
        idle(4);
        chk("w12_parallel", {4'h0, po_c}, 16'h0123);
        chk("w12_busy", 16'(bs_c), 16'h0000);

        chk("rxq_empty", 16'(rxq.size()), 16'h0000);
        chk("txq_empty", 16'(txq.size()), 16'h0000);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
